// File: rtl/c17_bist_array_if.sv
// BIST control/status bundle for c17_bist_array: run control, golden signature and results.
interface c17_bist_array_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                    start;
  logic                    abort;
  logic [2*CHANNELS-1:0]   golden_sig;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [2*CHANNELS-1:0]   signature;

  modport master (
    output start, abort, golden_sig,
    input  busy, done, pass, signature
  );

  modport slave (
    input  start, abort, golden_sig,
    output busy, done, pass, signature
  );
endinterface

// File: rtl/c17_bist_array.sv
// CHANNELS copies of the c17 NAND network with an LFSR/MISR self-test controller.
// Optional stuck-at fault injection is compiled in with `define C17_FAULT_INJECT_EN.
module c17_bist_array #(
  parameter int unsigned          CHANNELS  = 4,
  parameter int unsigned          PATTERNS  = 256,
  parameter int unsigned          LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0]    SEED      = 16'h0001,
  parameter logic [2*CHANNELS-1:0] MISR_TAPS = 8'hB8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*CHANNELS-1:0]   func_in,
  output logic [2*CHANNELS-1:0]   func_out,
  c17_bist_array_if.slave         bist,
  input  logic                    fi_enable,
  input  logic [3:0]              fi_chan,
  input  logic [3:0]              fi_net,
  input  logic                    fi_value
);

  localparam int unsigned W    = 2 * CHANNELS;
  localparam int unsigned CntW = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
  localparam logic [LFSR_W-1:0] SeedEff = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [CntW-1:0]   CntLast = CntW'(PATTERNS - 1);

  typedef enum logic [1:0] {StIdle, StSeed, StRun, StDone} state_e;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic [W-1:0]      misr_q, misr_nxt;
  logic [CntW-1:0]   cnt_q;
  logic [W-1:0]      func_out_q;
  logic              busy_q, done_q, pass_q;
  logic [W-1:0]      resp, func_nxt;

  logic              fi_en_eff;
  logic [3:0]        fi_chan_eff, fi_net_eff;
  logic              fi_value_eff;

`ifdef C17_FAULT_INJECT_EN
  assign fi_en_eff    = fi_enable;
  assign fi_chan_eff  = fi_chan;
  assign fi_net_eff   = fi_net;
  assign fi_value_eff = fi_value;
`else
  logic unused_fi;
  assign unused_fi    = ^{fi_enable, fi_chan, fi_net, fi_value};
  assign fi_en_eff    = 1'b0;
  assign fi_chan_eff  = 4'd0;
  assign fi_net_eff   = 4'd0;
  assign fi_value_eff = 1'b0;
`endif

  // x = {N7,N6,N3,N2,N1}; net order N1,N2,N3,N6,N7,N10,N11,N16,N19,N22,N23.
  // Net codes 11..15 shift the one-hot past bit 10 and so force nothing.
  function automatic logic [1:0] c17_eval(input logic [4:0] x, input logic hit,
                                          input logic [3:0] net, input logic val);
    logic [10:0] f;
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
    f   = hit ? (11'b1 << net) : 11'b0;
    n1  = f[0]  ? val : x[0];
    n2  = f[1]  ? val : x[1];
    n3  = f[2]  ? val : x[2];
    n6  = f[3]  ? val : x[3];
    n7  = f[4]  ? val : x[4];
    n10 = f[5]  ? val : ~(n1 & n3);
    n11 = f[6]  ? val : ~(n3 & n6);
    n16 = f[7]  ? val : ~(n2 & n11);
    n19 = f[8]  ? val : ~(n11 & n7);
    n22 = f[9]  ? val : ~(n10 & n16);
    n23 = f[10] ? val : ~(n16 & n19);
    return {n23, n22};
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [4:0] bist_x;
    logic       hit;
    for (genvar j = 0; j < 5; j++) begin : g_bit
      assign bist_x[j] = lfsr_q[(5*k+j) % LFSR_W];
    end
    assign hit = fi_en_eff && (fi_chan_eff == 4'(k));
    assign resp[2*k+1:2*k]     = c17_eval(bist_x, hit, fi_net_eff, fi_value_eff);
    assign func_nxt[2*k+1:2*k] = c17_eval(func_in[5*k+4:5*k], hit, fi_net_eff, fi_value_eff);
  end

  assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign misr_nxt = {misr_q[W-2:0], 1'b0} ^ (misr_q[W-1] ? MISR_TAPS : '0) ^ resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= SeedEff;
      misr_q     <= '0;
      cnt_q      <= '0;
      func_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          func_out_q <= func_nxt;
          if (bist.start) begin
            state_q <= StSeed;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StSeed: begin
          if (bist.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            lfsr_q  <= SeedEff;
            misr_q  <= '0;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Abort leaves the partial signature visible for debug.
          if (bist.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            misr_q <= misr_nxt;
            lfsr_q <= lfsr_nxt;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (misr_nxt == bist.golden_sig);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign func_out       = func_out_q;
  assign bist.busy      = busy_q;
  assign bist.done      = done_q;
  assign bist.pass      = pass_q;
  assign bist.signature = misr_q;

endmodule
